gol_grid_uart_dump: RTL and testbench
=====================================

// Module: gol_grid_uart_dump
// PURPOSE
//  Read side of the cell-state bus: snapshots the L*L Game-of-Life status vector on each
//  generation tick and serialises it as an ASCII frame over a UART 8N1 line for host capture.
//  Sits beside the VGA path in the top level, fed by the cell array's status bus and the
//  CA evolution clock. Lets the host log generations for off-board checking.
// PARAMETERS
//  L             16          grid side; must be 2, 4, 8 or 16; grid has L*L cells
//  CLKS_PER_BIT  434         clock cycles per UART bit (50 MHz / 115200); must be >= 2
// PORTS
//  CLK_50M         in   1      system clock; single clock domain
//  rst             in   1      synchronous, active-high reset
//  gen_tick        in   1      CA evolution clock (same domain); a rising edge marks a new generation
//  enable          in   1      1 = dump frames; 0 = ignore ticks
//  status          in   L*L    cell states; bit L*row+col, 1 = alive
//  uart_tx         out  1      serial line; idle high
//  busy            out  1      high while a frame is in flight
//  frames_dropped  out  8      ticks lost while busy; saturating
// BEHAVIOUR
//  Reset: uart_tx=1, busy=0, frames_dropped=0, tick_q=1.
//   tick_q=1 blocks a spurious edge when gen_tick is high as reset releases.
//  Edge detect: edge = gen_tick & ~tick_q. tick_q <= gen_tick every cycle.
//  Frame start: edge & enable & ~busy in cycle n. At the clock edge ending cycle n,
//   snapshot <= status and busy <= 1. The start bit (uart_tx=0) begins at the following edge.
//  Drop: edge & enable & busy -> frames_dropped += 1, saturating at 255. The snapshot is untouched.
//  An edge with enable=0 is ignored and is not counted.
//  Frame content: 1 + L*(L+2) bytes; 289 bytes for L=16.
//   Header byte 0x23 ('#').
//   Then rows 0..L-1. Each row sends cols 0..L-1: 0x4F ('O') if snapshot[L*row+col]=1,
//    else 0x2E ('.'). Each row ends with 0x0D, 0x0A.
//  Byte FSM: IDLE -> START -> DATA -> STOP.
//   START sends a low start bit.
//   DATA sends 8 bits, LSB first.
//   STOP sends a high stop bit.
//   Every state lasts exactly CLKS_PER_BIT cycles.
//   At the end of STOP: if more bytes remain, go to START of the next byte with no idle gap;
//    otherwise go to IDLE and drop busy to 0 in the same cycle.
//  Sequencer: row counter 0..L-1 and col counter 0..L+1 (col L = CR, col L+1 = LF), plus a
//   header flag. Counters advance only when a byte completes.
//  Width rules: the bit counter is clog2(CLKS_PER_BIT) bits and wraps at CLKS_PER_BIT-1.
//   Indexing uses L*row+col, never mod arithmetic.
//  Changes to status or enable mid-frame do not affect the frame in flight.
//  rst mid-frame aborts the frame: uart_tx=1 and busy=0 at the next edge. No partial byte
//   is resumed. The next accepted tick starts at the header.
// STRUCTURE
//  Shared package gol_pkg holds L and the character constants CH_HDR=8'h23, CH_ALIVE=8'h4F,
//   CH_DEAD=8'h2E, CH_CR=8'h0D, CH_LF=8'h0A. The UART FSM state enum also lives there.
//  One sub-module: uart_tx_byte. It is an 8N1 serializer with a valid/ready handshake;
//   a byte is accepted when valid & ready, and ready is high only in IDLE or on the final
//   cycle of STOP.
//  The top of this block holds the edge detect, the snapshot register, the row/col
//   sequencer and the drop counter.
// TESTING (L=4, CLKS_PER_BIT=4, so a frame is 25 bytes and 1000 bit-cycles)
//  1 Reset: hold rst=1 for 3 cycles with gen_tick=1, then release.
//    -> uart_tx=1, busy=0, frames_dropped=0, and no frame is ever started.
//  2 Basic frame: status=16'h0001, pulse gen_tick.
//    -> UART decode gives "#", "O...\r\n", then "....\r\n" three times.
//    -> Every bit lasts exactly 4 cycles. busy goes low 1000 cycles after the start bit.
//  3 Snapshot hold: status=16'hF000, tick, then status=16'h0000 after 50 cycles.
//    -> the last row decodes as "OOOO\r\n".
//  4 Drop: a second tick during a frame gives frames_dropped=1.
//    -> 300 ticks while busy leave frames_dropped at 255 with no wrap.
//  5 Disable: enable=0, then a tick -> uart_tx stays 1, busy stays 0, counter is unchanged.
//  6 Abort: assert rst in the middle of byte 5 -> uart_tx=1 and busy=0 at the next edge.
//    -> the next tick sends a complete frame starting with 0x23.

Source files
------------

// File: rtl/gol_pkg.sv
// gol_pkg: shared constants and types for the Game-of-Life UART frame dumper.
//   GOL_L         default grid side
//   CH_*          ASCII bytes used to build a frame
//   uart_state_e  byte serializer states
package gol_pkg;

    localparam int GOL_L = 16;

    localparam logic [7:0] CH_HDR   = 8'h23;  // '#'
    localparam logic [7:0] CH_ALIVE = 8'h4F;  // 'O'
    localparam logic [7:0] CH_DEAD  = 8'h2E;  // '.'
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/gol_grid_uart_dump_uart_tx_byte.sv
// uart_tx_byte: 8N1 serializer with a valid/ready byte handshake.
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   i_valid  in   byte offered
//   i_data   in   byte to send
//   o_ready  out  high in IDLE and on the last cycle of STOP; byte taken on valid & ready
//   o_tx     out  registered serial line, idle high
// Taking a byte on the last STOP cycle chains bytes with no idle gap.
module uart_tx_byte
    import gol_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_tx
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    uart_state_e      r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic [2:0]       r_bit,   w_bit_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic             r_tx,    w_tx_nxt;
    logic             w_cnt_done;

    assign w_cnt_done = (r_cnt == CNT_LAST);
    assign o_tx       = r_tx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    // The line value is set on the transition into each bit, so o_tx is glitch-free
    // and each bit holds for exactly CLKS_PER_BIT cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        o_ready     = 1'b0;

        case (r_state)
            S_IDLE: begin
                o_ready  = 1'b1;
                w_tx_nxt = 1'b1;
                if (i_valid) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = '0;
                    w_shift_nxt = i_data;
                    w_tx_nxt    = 1'b0;
                end
            end
            S_START: begin
                if (w_cnt_done) begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = r_shift[0];
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (w_cnt_done) begin
                    w_cnt_nxt = '0;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        // shift register keeps the current bit at [0]
                        w_bit_nxt   = r_bit + 3'd1;
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_tx_nxt    = r_shift[1];
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (w_cnt_done) begin
                    o_ready   = 1'b1;
                    w_cnt_nxt = '0;
                    if (i_valid) begin
                        w_state_nxt = S_START;
                        w_shift_nxt = i_data;
                        w_tx_nxt    = 1'b0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/gol_grid_uart_dump.sv
// gol_grid_uart_dump: snapshots the L*L cell-status vector on each rising edge of
// gen_tick and sends it as an ASCII frame over UART 8N1.
// Frame: '#', then L rows of L chars ('O' alive / '.' dead) each followed by CR LF.
//   CLK_50M         in   system clock
//   rst             in   synchronous active-high reset; aborts any frame in flight
//   gen_tick        in   generation clock, same domain; rising edge = new generation
//   enable          in   1 = dump frames on ticks
//   status          in   cell states, bit L*row+col
//   uart_tx         out  serial line, idle high
//   busy            out  frame in flight
//   frames_dropped  out  accepted-enable ticks seen while busy, saturating at 255
module gol_grid_uart_dump
    import gol_pkg::*;
#(
    parameter int L            = GOL_L,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic           CLK_50M,
    input  logic           rst,
    input  logic           gen_tick,
    input  logic           enable,
    input  logic [L*L-1:0] status,
    output logic           uart_tx,
    output logic           busy,
    output logic [7:0]     frames_dropped
);

    localparam int ROW_W = (L > 1) ? $clog2(L) : 1;
    localparam int COL_W = $clog2(L + 2);
    localparam int IDX_W = $clog2(L * L);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(L - 1);
    localparam logic [COL_W-1:0] COL_CR   = COL_W'(L);
    localparam logic [COL_W-1:0] COL_LF   = COL_W'(L + 1);

    logic             r_tick_q;
    logic             r_busy;
    logic [7:0]       r_drop;
    logic [L*L-1:0]   r_snap;
    logic             r_hdr;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic             r_all_sent;   // last byte already handed to the serializer

    logic             w_edge;
    logic             w_start;
    logic             w_drop;
    logic             w_valid;
    logic             w_ready;
    logic             w_fire;
    logic             w_done;
    logic [IDX_W-1:0] w_idx;
    logic [7:0]       w_byte;

    assign w_edge  = gen_tick & ~r_tick_q;
    assign w_start = w_edge & enable & ~r_busy;
    assign w_drop  = w_edge & enable & r_busy;

    assign w_valid = r_busy & ~r_all_sent;
    assign w_fire  = w_valid & w_ready;
    // Serializer asks for another byte at the end of the final stop bit: frame over.
    assign w_done  = r_busy & r_all_sent & w_ready;

    // Only meaningful for col < L; CR/LF columns never read it.
    assign w_idx = IDX_W'(L * int'(r_row) + int'(r_col));

    always_comb begin
        w_byte = CH_DEAD;
        if (r_hdr) begin
            w_byte = CH_HDR;
        end else if (r_col == COL_CR) begin
            w_byte = CH_CR;
        end else if (r_col == COL_LF) begin
            w_byte = CH_LF;
        end else if (r_snap[w_idx]) begin
            w_byte = CH_ALIVE;
        end
    end

    always_ff @(posedge CLK_50M) begin
        if (rst) begin
            // tick_q starts high so a tick held high through reset is not an edge
            r_tick_q   <= 1'b1;
            r_busy     <= 1'b0;
            r_drop     <= '0;
            r_snap     <= '0;
            r_hdr      <= 1'b1;
            r_row      <= '0;
            r_col      <= '0;
            r_all_sent <= 1'b0;
        end else begin
            r_tick_q <= gen_tick;

            if (w_start) begin
                r_snap     <= status;
                r_busy     <= 1'b1;
                r_hdr      <= 1'b1;
                r_row      <= '0;
                r_col      <= '0;
                r_all_sent <= 1'b0;
            end else begin
                if (w_fire) begin
                    if (r_hdr) begin
                        r_hdr <= 1'b0;
                    end else if (r_col == COL_LF) begin
                        r_col <= '0;
                        if (r_row == ROW_LAST) begin
                            r_all_sent <= 1'b1;
                        end else begin
                            r_row <= r_row + ROW_W'(1);
                        end
                    end else begin
                        r_col <= r_col + COL_W'(1);
                    end
                end
                if (w_done) begin
                    r_busy <= 1'b0;
                end
            end

            if (w_drop && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clk     (CLK_50M),
        .rst     (rst),
        .i_valid (w_valid),
        .i_data  (w_byte),
        .o_ready (w_ready),
        .o_tx    (uart_tx)
    );

    assign busy           = r_busy;
    assign frames_dropped = r_drop;

endmodule

// File: tb/tb_gol_grid_uart_dump.sv
module tb_gol_grid_uart_dump;

    localparam int L      = 4;
    localparam int CPB    = 4;
    localparam int NBYTES = 1 + L * (L + 2);
    localparam int FCYC   = NBYTES * 10 * CPB;

    logic           clk      = 1'b0;
    logic           rst      = 1'b1;
    logic           gen_tick = 1'b0;
    logic           enable   = 1'b1;
    logic [L*L-1:0] status   = '0;
    logic           uart_tx;
    logic           busy;
    logic [7:0]     frames_dropped;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         bytes_rx = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gol_grid_uart_dump #(
        .L            (L),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .CLK_50M        (clk),
        .rst            (rst),
        .gen_tick       (gen_tick),
        .enable         (enable),
        .status         (status),
        .uart_tx        (uart_tx),
        .busy           (busy),
        .frames_dropped (frames_dropped)
    );

    // UART monitor: captures 40 samples per byte, checks every bit lasts CPB cycles,
    // then pops the scoreboard and compares.
    initial begin : monitor
        logic [39:0] sv;
        logic [7:0]  b;
        logic [7:0]  e;
        logic        active;
        logic        tim_ok;
        int          k;
        active = 1'b0;
        k      = 0;
        sv     = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 1'b0;
            end else if (!active) begin
                if (uart_tx === 1'b0) begin
                    active = 1'b1;
                    sv     = '0;
                    k      = 1;
                end
            end else begin
                sv[k] = uart_tx;
                k++;
                if (k == 40) begin
                    active = 1'b0;
                    tim_ok = 1'b1;
                    for (int g = 0; g < 10; g++)
                        for (int j = 1; j < 4; j++)
                            if (sv[g*4+j] !== sv[g*4]) tim_ok = 1'b0;
                    if (sv[36] !== 1'b1) tim_ok = 1'b0;
                    for (int i = 0; i < 8; i++) b[i] = sv[(i+1)*4];
                    n_checks++;
                    if (!tim_ok) begin
                        n_fail++;
                        $display("FAIL bit_timing byte#%0d samples=%h required 4-cycle bits, stop=1", bytes_rx, sv);
                    end
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_byte got=%h required=none", b);
                    end else begin
                        e = exp_q.pop_front();
                        if (b !== e) begin
                            n_fail++;
                            $display("FAIL byte_value byte#%0d got=%h required=%h", bytes_rx, b, e);
                        end
                    end
                    bytes_rx++;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        @(posedge clk);
        #1 gen_tick = 1'b1;
        @(posedge clk);
        #1 gen_tick = 1'b0;
    endtask

    task automatic push_frame(input logic [L*L-1:0] s);
        exp_q.push_back(8'h23);
        for (int r = 0; r < L; r++) begin
            for (int c = 0; c < L; c++) exp_q.push_back(s[L*r+c] ? 8'h4F : 8'h2E);
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy === 1'b1 && n < FCYC + 200) begin
            step(1);
            n++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_timeout busy=%b required=0 after %0d cycles", name, busy, n);
        end
    endtask

    task automatic check_drained(input string name);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drained left=%0d required=0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        logic ok;
        rst      = 1'b1;
        gen_tick = 1'b1;
        step(3);
        rst = 1'b0;
        n_checks++;
        if (uart_tx !== 1'b1 || busy !== 1'b0 || frames_dropped !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_state tx=%b busy=%b drop=%0d required 1/0/0", uart_tx, busy, frames_dropped);
        end
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (busy !== 1'b0 || uart_tx !== 1'b1) ok = 1'b0;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL reset_no_spurious_frame tx=%b busy=%b required idle", uart_tx, busy);
        end
        gen_tick = 1'b0;
        step(2);
    endtask

    task automatic test_basic_frame();
        int t0, rx0, n;
        rx0    = bytes_rx;
        status = 16'h0001;
        push_frame(status);
        pulse_tick();
        n_checks++;
        if (busy !== 1'b1 || uart_tx !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_accept busy=%b tx=%b required 1/1", busy, uart_tx);
        end
        step(1);
        n_checks++;
        if (uart_tx !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_start_latency tx=%b required 0", uart_tx);
        end
        t0 = cyc;
        n  = 0;
        while (busy === 1'b1 && n < FCYC + 100) begin
            step(1);
            n++;
        end
        n_checks++;
        if (cyc - t0 != FCYC || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_frame_length cycles=%0d busy=%b required %0d/0", cyc - t0, busy, FCYC);
        end
        step(2);
        check_drained("basic");
        n_checks++;
        if (bytes_rx - rx0 != NBYTES || uart_tx !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_byte_count got=%0d tx=%b required %0d/1", bytes_rx - rx0, uart_tx, NBYTES);
        end
    endtask

    task automatic test_snapshot_hold();
        status = 16'hF000;
        push_frame(status);
        pulse_tick();
        step(50);
        status = 16'h0000;
        wait_idle("snapshot");
        step(2);
        check_drained("snapshot");
    endtask

    task automatic test_disable();
        logic ok;
        status = 16'h5A5A;
        push_frame(status);
        pulse_tick();
        step(30);
        enable = 1'b0;
        status = 16'hFFFF;
        pulse_tick();
        n_checks++;
        if (frames_dropped !== 8'd0) begin
            n_fail++;
            $display("FAIL disable_busy_no_count drop=%0d required 0", frames_dropped);
        end
        wait_idle("disable_midframe");
        step(2);
        check_drained("disable_midframe");
        pulse_tick();
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (busy !== 1'b0 || uart_tx !== 1'b1) ok = 1'b0;
            step(1);
        end
        n_checks++;
        if (!ok || frames_dropped !== 8'd0) begin
            n_fail++;
            $display("FAIL disable_idle tx=%b busy=%b drop=%0d required 1/0/0", uart_tx, busy, frames_dropped);
        end
        enable = 1'b1;
        step(2);
    endtask

    task automatic test_drop();
        status = 16'h8421;
        push_frame(status);
        pulse_tick();
        step(100);
        status = 16'h1234;
        pulse_tick();
        n_checks++;
        if (frames_dropped !== 8'd1) begin
            n_fail++;
            $display("FAIL drop_one drop=%0d required 1", frames_dropped);
        end
        for (int i = 0; i < 300; i++) begin
            status = 16'(i * 37);
            pulse_tick();
        end
        n_checks++;
        if (frames_dropped !== 8'd255 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_saturate drop=%0d busy=%b required 255/1", frames_dropped, busy);
        end
        wait_idle("drop");
        step(2);
        check_drained("drop");
        n_checks++;
        if (frames_dropped !== 8'd255) begin
            n_fail++;
            $display("FAIL drop_hold drop=%0d required 255", frames_dropped);
        end
    endtask

    task automatic test_abort();
        status = 16'hC3C3;
        push_frame(status);
        pulse_tick();
        step(1 + 4 * 10 * CPB + 20);   // middle of byte 5
        n_checks++;
        if (exp_q.size() != NBYTES - 4) begin
            n_fail++;
            $display("FAIL abort_progress left=%0d required %0d", exp_q.size(), NBYTES - 4);
        end
        rst = 1'b1;
        step(1);
        n_checks++;
        if (uart_tx !== 1'b1 || busy !== 1'b0 || frames_dropped !== 8'd0) begin
            n_fail++;
            $display("FAIL abort_reset tx=%b busy=%b drop=%0d required 1/0/0", uart_tx, busy, frames_dropped);
        end
        rst = 1'b0;
        exp_q.delete();
        step(5);
        n_checks++;
        if (uart_tx !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_stays_idle tx=%b busy=%b required 1/0", uart_tx, busy);
        end
        status = 16'h0F0F;
        push_frame(status);
        pulse_tick();
        wait_idle("abort_restart");
        step(2);
        check_drained("abort_restart");
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_snapshot_hold();
        test_disable();
        test_drop();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
